// File: rtl/v_rams_sp_cfg_pkg.sv
// Shared definitions for the single-port RAM: collision-mode codes and clear FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rams_pkg;

  // Read/write collision behaviour of the user port
  localparam int WM_READ_FIRST  = 0;
  localparam int WM_WRITE_FIRST = 1;
  localparam int WM_NO_CHANGE   = 2;

  // Clear sequencer states
  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } clr_state_e;

endpackage

// File: rtl/v_rams_sp_cfg_if.sv
// User port bundle of the single-port RAM (enable, byte writes, address, data, status).
// Latency: n/a (wires only).
// Backpressure: busy from the RAM tells the master that requests are being dropped.
interface v_rams_sp_cfg_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6,
  parameter int NB     = 2
);
  logic              en;
  logic [NB-1:0]     we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] di;
  logic [DATA_W-1:0] dout;
  logic              do_valid;
  logic              busy;

  modport master (output en, we, addr, di, input dout, do_valid, busy);
  modport slave  (input en, we, addr, di, output dout, do_valid, busy);
endinterface

// File: rtl/v_rams_sp_cfg_clear_seq.sv
// Clear sequencer: walks every word address once after reset, then hands the RAM to the user.
// Latency: DEPTH cycles from rst_n release to busy low.
// Backpressure: busy stays high for the whole sweep; a new reset restarts the sweep at 0.
module rams_clear_seq
  import rams_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;

  // State and counter registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state: one word cleared per cycle, leave CLEAR after writing the last word
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    busy      = 1'b0;
    clr_we    = 1'b0;
    clr_addr  = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        busy      = 1'b1;
        clr_we    = rst_n;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) state_d = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b0;
      end
      default: state_d = ST_CLEAR;
    endcase
  end

endmodule

// File: rtl/v_rams_sp_cfg.sv
// Single-port RAM with byte-lane writes, READ_FIRST/WRITE_FIRST/NO_CHANGE modes and self-clear.
// Latency: 1 cycle en->dout/do_valid, 2 cycles when V_RAMS_SP_OUT_REG_EN is defined.
// Backpressure: user requests are dropped while busy (reset and the DEPTH-cycle clear sweep).
module v_rams_sp_cfg
  import rams_pkg::*;
#(
  parameter int              DATA_W     = 16,
  parameter int              ADDR_W     = 6,
  parameter int              BYTE_W     = 8,
  parameter int              WRITE_MODE = 0,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input logic            clk,
  input logic            rst_n,
  v_rams_sp_cfg_if.slave bus
);
  localparam int NB    = DATA_W / BYTE_W;
  localparam int DEPTH = 1 << ADDR_W;

  logic              busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              usr_en;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] old_w, lane_mask, merged_w;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              rd_vld_q, rd_vld_d;

  if (DATA_W % BYTE_W != 0) begin : g_bad_width
    $error("DATA_W must be a multiple of BYTE_W");
  end

  rams_clear_seq #(.ADDR_W(ADDR_W)) u_clear_seq (
    .clk      (clk),
    .rst_n    (rst_n),
    .busy     (busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );

  assign usr_en   = bus.en & ~busy;
  assign bus.busy = busy;
  assign old_w    = mem[bus.addr];

  // Expand lane enables to a bit mask and build the post-write word
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < NB; i++) lane_mask[i*BYTE_W +: BYTE_W] = {BYTE_W{bus.we[i]}};
    merged_w = (old_w & ~lane_mask) | (bus.di & lane_mask);
  end

  // Memory write port: clear sweep has priority, user writes only outside busy
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= INIT_VAL;
    end else if (usr_en) begin
      for (int i = 0; i < NB; i++)
        if (bus.we[i]) mem[bus.addr][i*BYTE_W +: BYTE_W] <= bus.di[i*BYTE_W +: BYTE_W];
    end
  end

  if (WRITE_MODE == WM_READ_FIRST) begin : g_read_first
    // Read stage: old word, regardless of lanes being written
    always_comb begin
      rd_d     = rd_q;
      rd_vld_d = 1'b0;
      if (usr_en) begin
        rd_d     = old_w;
        rd_vld_d = 1'b1;
      end
    end
  end else if (WRITE_MODE == WM_WRITE_FIRST) begin : g_write_first
    // Read stage: written lanes bypass from di, others from the old word
    always_comb begin
      rd_d     = rd_q;
      rd_vld_d = 1'b0;
      if (usr_en) begin
        rd_d     = merged_w;
        rd_vld_d = 1'b1;
      end
    end
  end else if (WRITE_MODE == WM_NO_CHANGE) begin : g_no_change
    // Read stage: any write keeps the previous output and produces no result
    always_comb begin
      rd_d     = rd_q;
      rd_vld_d = 1'b0;
      if (usr_en && (bus.we == '0)) begin
        rd_d     = old_w;
        rd_vld_d = 1'b1;
      end
    end
  end else begin : g_bad_mode
    $error("WRITE_MODE must be 0, 1 or 2");
  end

  // Read-stage registers; cleared by reset so a pending result is dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_q     <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_q     <= rd_d;
      rd_vld_q <= rd_vld_d;
    end
  end

`ifdef V_RAMS_SP_OUT_REG_EN
  logic [DATA_W-1:0] out_q, out_d;
  logic              out_vld_q, out_vld_d;

  // Output stage follows the read stage every cycle
  always_comb begin
    out_d     = rd_q;
    out_vld_d = rd_vld_q;
  end

  // Output stage registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= '0;
      out_vld_q <= 1'b0;
    end else begin
      out_q     <= out_d;
      out_vld_q <= out_vld_d;
    end
  end

  assign bus.dout     = out_q;
  assign bus.do_valid = out_vld_q;
`else
  assign bus.dout     = rd_q;
  assign bus.do_valid = rd_vld_q;
`endif

endmodule

// File: tb/tb_v_rams_sp_cfg.sv
// Bench for v_rams_sp_cfg: one instance per collision mode, driven in lockstep.
// Latency: expectations are queued per cycle and compared LAT cycles later.
// Backpressure: the reference model drops requests while its clear countdown runs.
module tb_v_rams_sp_cfg;
  import rams_pkg::*;

`ifdef V_RAMS_SP_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [1:0]  we;
  logic [5:0]  addr;
  logic [15:0] di;

  always #5 clk = ~clk;

  v_rams_sp_cfg_if #(.DATA_W(16), .ADDR_W(6), .NB(2)) if_rf ();
  v_rams_sp_cfg_if #(.DATA_W(16), .ADDR_W(6), .NB(2)) if_wf ();
  v_rams_sp_cfg_if #(.DATA_W(16), .ADDR_W(6), .NB(2)) if_nc ();

  assign if_rf.en = en; assign if_rf.we = we; assign if_rf.addr = addr; assign if_rf.di = di;
  assign if_wf.en = en; assign if_wf.we = we; assign if_wf.addr = addr; assign if_wf.di = di;
  assign if_nc.en = en; assign if_nc.we = we; assign if_nc.addr = addr; assign if_nc.di = di;

  v_rams_sp_cfg #(.DATA_W(16), .ADDR_W(6), .BYTE_W(8), .WRITE_MODE(WM_READ_FIRST), .INIT_VAL(16'h0000))
    u_rf (.clk(clk), .rst_n(rst_n), .bus(if_rf));
  v_rams_sp_cfg #(.DATA_W(16), .ADDR_W(6), .BYTE_W(8), .WRITE_MODE(WM_WRITE_FIRST), .INIT_VAL(16'h0000))
    u_wf (.clk(clk), .rst_n(rst_n), .bus(if_wf));
  v_rams_sp_cfg #(.DATA_W(16), .ADDR_W(6), .BYTE_W(8), .WRITE_MODE(WM_NO_CHANGE), .INIT_VAL(16'h0000))
    u_nc (.clk(clk), .rst_n(rst_n), .bus(if_nc));

  int n_chk  = 0;
  int n_pass = 0;

  // Reference state
  logic [15:0] mm [DEPTH];
  logic [15:0] last [3];
  int          left  = 0;
  bit          known = 1'b0;
  logic [16:0] q_rf[$], q_wf[$], q_nc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
  endtask

  task automatic push(input int k, input logic vld, input logic [15:0] d);
    case (k)
      0:       q_rf.push_back({vld, d});
      1:       q_wf.push_back({vld, d});
      default: q_nc.push_back({vld, d});
    endcase
  endtask

  // Compare outputs of each instance against the oldest matured expectation
  task automatic check_outputs();
    logic [16:0] e;
    if (q_rf.size() >= LAT) begin
      e = q_rf.pop_front();
      chk("rf_vld", {31'b0, if_rf.do_valid}, {31'b0, e[16]});
      chk("rf_do", {16'b0, if_rf.dout}, {16'b0, e[15:0]});
    end
    if (q_wf.size() >= LAT) begin
      e = q_wf.pop_front();
      chk("wf_vld", {31'b0, if_wf.do_valid}, {31'b0, e[16]});
      chk("wf_do", {16'b0, if_wf.dout}, {16'b0, e[15:0]});
    end
    if (q_nc.size() >= LAT) begin
      e = q_nc.pop_front();
      chk("nc_vld", {31'b0, if_nc.do_valid}, {31'b0, e[16]});
      chk("nc_do", {16'b0, if_nc.dout}, {16'b0, e[15:0]});
    end
  endtask

  // One clock: check what matured, drive new inputs, predict the coming edge
  task automatic step(input logic r, input logic e, input logic [1:0] w,
                      input logic [5:0] a, input logic [15:0] d);
    logic [15:0] old, mrg, res;
    logic        vld;
    @(negedge clk);
    if (known) begin
      chk("busy_rf", {31'b0, if_rf.busy}, {31'b0, (left > 0)});
      chk("busy_wf", {31'b0, if_wf.busy}, {31'b0, (left > 0)});
      chk("busy_nc", {31'b0, if_nc.busy}, {31'b0, (left > 0)});
      check_outputs();
    end
    rst_n = r; en = e; we = w; addr = a; di = d;
    if (!r) begin
      known = 1'b1;
      left  = DEPTH;
      for (int k = 0; k < 3; k++) last[k] = 16'h0000;
      q_rf.delete(); q_wf.delete(); q_nc.delete();
    end else if (left > 0) begin
      left--;
      for (int k = 0; k < 3; k++) push(k, 1'b0, last[k]);
      if (left == 0) for (int i = 0; i < DEPTH; i++) mm[i] = 16'h0000;
    end else begin
      old = mm[a];
      mrg = old;
      if (w[0]) mrg[7:0]  = d[7:0];
      if (w[1]) mrg[15:8] = d[15:8];
      for (int k = 0; k < 3; k++) begin
        vld = 1'b0;
        res = last[k];
        if (e) begin
          if (k == 0) begin vld = 1'b1; res = old; end
          else if (k == 1) begin vld = 1'b1; res = mrg; end
          else if (w == 2'b00) begin vld = 1'b1; res = old; end
        end
        last[k] = res;
        push(k, vld, res);
      end
      if (e) mm[a] = mrg;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, 6'd0, 16'h0000);
  endtask

  task automatic wr(input logic [5:0] a, input logic [1:0] w, input logic [15:0] d);
    step(1'b1, 1'b1, w, a, d);
  endtask

  task automatic rd(input logic [5:0] a);
    step(1'b1, 1'b1, 2'b00, a, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; we = 2'b00; addr = '0; di = '0;

    // Power-up reset, clear sweep with ignored requests, then read back zeros
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000);
    for (int i = 0; i < 66; i++) step(1'b1, 1'b1, 2'b11, 6'(i), 16'hFFFF);
    for (int i = 0; i < DEPTH; i++) rd(6'(i));
    idle(2);

    // Full-word collision on addr 5, byte collision on addr 9
    wr(6'd5, 2'b11, 16'h1234);
    wr(6'd5, 2'b11, 16'hABCD);
    rd(6'd5);
    wr(6'd9, 2'b11, 16'h1234);
    wr(6'd9, 2'b01, 16'hABCD);
    idle(1);
    rd(6'd9);

    // Output holds across a write with NO_CHANGE semantics
    wr(6'd10, 2'b11, 16'h5555);
    rd(6'd10);
    wr(6'd3, 2'b11, 16'h0F0F);
    idle(2);
    rd(6'd3);
    wr(6'd3, 2'b10, 16'hAA00);
    rd(6'd3);
    idle(2);

    // Reset in the middle of a clear sweep restarts it
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000);
    for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 2'b11, 6'd3, 16'hDEAD);
    step(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000);
    for (int i = 0; i < 66; i++) step(1'b1, 1'b1, 2'b11, 6'(i), 16'hBEEF);
    rd(6'd3); rd(6'd5); rd(6'd9); rd(6'd10); rd(6'd63);

    // Streaming reads after a write
    wr(6'd7, 2'b11, 16'h00A7);
    wr(6'd6, 2'b11, 16'h0066);
    rd(6'd7); rd(6'd6); rd(6'd7); rd(6'd6);
    idle(3);

    // Random traffic on a small address window to provoke collisions
    for (int i = 0; i < 300; i++)
      step(1'b1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
           6'($urandom_range(0, 7)), 16'($urandom));
    idle(2);

    // Reset while a read is in flight drops it and re-clears memory
    rd(6'd7);
    step(1'b0, 1'b0, 2'b00, 6'd0, 16'h0000);
    for (int i = 0; i < 66; i++) idle(1);
    rd(6'd7); rd(6'd0);
    idle(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
